// File: rtl/morse_module_ctrl_if.sv
// Port bundle between the Morse puzzle controller and its surroundings.
// The buttons and arm are plain debounced levels, not handshakes. dbg_state exposes the controller FSM state.
interface morse_module_ctrl_if;
  logic        arm;
  logic        btn_up;
  logic        btn_down;
  logic        btn_tx;
  logic [15:0] blink_data;
  logic        blink_set;
  logic        blink_reset_n;
  logic [3:0]  freq_idx;
  logic        busy;
  logic        solved;
  logic        strike;
  logic [1:0]  strike_count;
  logic [2:0]  dbg_state;

  modport master (
    output arm, btn_up, btn_down, btn_tx,
    input  blink_data, blink_set, blink_reset_n, freq_idx, busy, solved,
           strike, strike_count, dbg_state
  );

  modport slave (
    input  arm, btn_up, btn_down, btn_tx,
    output blink_data, blink_set, blink_reset_n, freq_idx, busy, solved,
           strike, strike_count, dbg_state
  );
endinterface

// File: rtl/morse_module_ctrl.sv
// Morse puzzle game controller: picks a word, drives the blinker, judges the tuned frequency.
// Optional post-strike input lockout is enabled by defining MORSE_LOCKOUT_EN.
module morse_module_ctrl #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          MAX_STRIKES    = 3,
  parameter int          LOCKOUT_CYCLES = 50000
) (
  input logic                clk,
  input logic                reset,
  morse_module_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CHECK   = 3'd3,
`ifdef MORSE_LOCKOUT_EN
    LOCKOUT = 3'd5,
`endif
    SOLVED  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q;
  logic        up_q, down_q, tx_q;
  logic [2:0]  word_q, word_d;
  logic [3:0]  freq_q, freq_d;
  logic        strike_q, strike_d;
  logic [1:0]  count_q, count_d;
  logic        blink_set_c, blink_run_c;
  logic        rise_up, rise_down, rise_tx;
  logic        lfsr_fb;

  assign rise_up   = bus.btn_up   & ~up_q;
  assign rise_down = bus.btn_down & ~down_q;
  assign rise_tx   = bus.btn_tx   & ~tx_q;
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  function automatic logic [3:0] expected_idx(input logic [2:0] word);
    case (word)
      3'd1:    expected_idx = 4'd3;
      3'd2:    expected_idx = 4'd5;
      3'd3:    expected_idx = 4'd9;
      3'd4:    expected_idx = 4'd12;
      default: expected_idx = 4'd0;
    endcase
  endfunction

`ifdef MORSE_LOCKOUT_EN
  logic [15:0] lock_cnt_q, lock_cnt_d;
`else
  wire unused_lockout_cycles = ^LOCKOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    freq_d      = freq_q;
    strike_d    = 1'b0;
    count_d     = count_q;
    blink_set_c = 1'b0;
    blink_run_c = 1'b0;
`ifdef MORSE_LOCKOUT_EN
    lock_cnt_d  = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        freq_d = 4'd0;
        if (bus.arm) begin
          word_d  = {1'b0, lfsr_q[1:0]} + 3'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        blink_set_c = 1'b1;
        blink_run_c = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        blink_run_c = 1'b1;
        // A submit edge freezes the index so the judged value is the pre-edge one.
        if (rise_tx) state_d = CHECK;
        else if (rise_up && !rise_down && freq_q != 4'd15) freq_d = freq_q + 4'd1;
        else if (rise_down && !rise_up && freq_q != 4'd0)  freq_d = freq_q - 4'd1;
      end
      CHECK: begin
        blink_run_c = 1'b1;
        if (freq_q == expected_idx(word_q)) begin
          state_d = SOLVED;
        end else begin
          strike_d = 1'b1;
          if (count_q != 2'(MAX_STRIKES)) count_d = count_q + 2'd1;
`ifdef MORSE_LOCKOUT_EN
          lock_cnt_d = 16'(LOCKOUT_CYCLES - 1);
          state_d    = LOCKOUT;
`else
          state_d    = RUN;
`endif
        end
      end
`ifdef MORSE_LOCKOUT_EN
      LOCKOUT: begin
        blink_run_c = 1'b1;
        if (lock_cnt_q == 16'd0) state_d = RUN;
        else                     lock_cnt_d = lock_cnt_q - 16'd1;
      end
`endif
      SOLVED: state_d = SOLVED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q   <= LFSR_SEED;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      tx_q     <= 1'b0;
      word_q   <= 3'd0;
      freq_q   <= 4'd0;
      strike_q <= 1'b0;
      count_q  <= 2'd0;
`ifdef MORSE_LOCKOUT_EN
      lock_cnt_q <= 16'd0;
`endif
    end else begin
      lfsr_q   <= {lfsr_q[14:0], lfsr_fb};
      up_q     <= bus.btn_up;
      down_q   <= bus.btn_down;
      tx_q     <= bus.btn_tx;
      word_q   <= word_d;
      freq_q   <= freq_d;
      strike_q <= strike_d;
      count_q  <= count_d;
`ifdef MORSE_LOCKOUT_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign bus.blink_data    = {13'd0, word_q};
  assign bus.blink_set     = blink_set_c;
  assign bus.blink_reset_n = blink_run_c;
  assign bus.freq_idx      = freq_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.solved        = (state_q == SOLVED);
  assign bus.strike        = strike_q;
  assign bus.strike_count  = count_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_morse_module_ctrl.sv
// Directed testbench for morse_module_ctrl (default build, lockout disabled).
module tb_morse_module_ctrl;
  localparam logic [31:0] ST_IDLE   = 32'd0;
  localparam logic [31:0] ST_LOAD   = 32'd1;
  localparam logic [31:0] ST_RUN    = 32'd2;
  localparam logic [31:0] ST_CHECK  = 32'd3;
  localparam logic [31:0] ST_SOLVED = 32'd4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  int   strike_seen = 0;
  int   strike_base;

  morse_module_ctrl_if bus();

  morse_module_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) strike_seen <= strike_seen + int'(bus.strike);

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " freq_idx"},      32'(bus.freq_idx),      32'd0);
    check_eq({tag, " busy"},          32'(bus.busy),          32'd0);
    check_eq({tag, " solved"},        32'(bus.solved),        32'd0);
    check_eq({tag, " strike"},        32'(bus.strike),        32'd0);
    check_eq({tag, " strike_count"},  32'(bus.strike_count),  32'd0);
    check_eq({tag, " blink_set"},     32'(bus.blink_set),     32'd0);
    check_eq({tag, " blink_reset_n"}, 32'(bus.blink_reset_n), 32'd0);
    check_eq({tag, " blink_data"},    32'(bus.blink_data),    32'd0);
    check_eq({tag, " state"},         32'(bus.dbg_state),     ST_IDLE);
  endtask

  // Reset, then arm on the first free cycle so the seed picks word 2.
  task automatic start(input string tag);
    reset = 1'b0;
    bus.arm = 1'b0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_tx = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    check_eq({tag, " load blink_set"},     32'(bus.blink_set),     32'd1);
    check_eq({tag, " load blink_data"},    32'(bus.blink_data),    32'd2);
    check_eq({tag, " load blink_reset_n"}, 32'(bus.blink_reset_n), 32'd1);
    tick();
    check_eq({tag, " run blink_set"}, 32'(bus.blink_set), 32'd0);
    check_eq({tag, " run state"},     32'(bus.dbg_state), ST_RUN);
  endtask

  task automatic press(input logic up, input logic down, input int times);
    for (int i = 0; i < times; i++) begin
      bus.btn_up = up;
      bus.btn_down = down;
      tick();
      bus.btn_up = 1'b0;
      bus.btn_down = 1'b0;
      tick();
    end
  endtask

  // tx rise (optionally with up), leaves the bench just after the judging edge.
  task automatic submit(input string tag, input logic with_up);
    bus.btn_tx = 1'b1;
    bus.btn_up = with_up;
    tick();
    bus.btn_tx = 1'b0;
    bus.btn_up = 1'b0;
    check_eq({tag, " check state"},  32'(bus.dbg_state), ST_CHECK);
    check_eq({tag, " check solved"}, 32'(bus.solved),    32'd0);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    bus.arm = 1'b0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_tx = 1'b0;
    tick();
    tick();
    check_all_zero("reset");

    // correct on first try
    start("t1");
    strike_base = strike_seen;
    press(1'b1, 1'b0, 5);
    check_eq("t1 freq", 32'(bus.freq_idx), 32'd5);
    submit("t1", 1'b0);
    check_eq("t1 solved",        32'(bus.solved),        32'd1);
    check_eq("t1 blink_reset_n", 32'(bus.blink_reset_n), 32'd0);
    check_eq("t1 state",         32'(bus.dbg_state),     ST_SOLVED);
    press(1'b1, 1'b0, 2);
    check_eq("t1 freq held",  32'(bus.freq_idx), 32'd5);
    check_eq("t1 no strikes", 32'(strike_seen - strike_base), 32'd0);

    // one wrong then correct
    start("t2");
    press(1'b1, 1'b0, 4);
    strike_base = strike_seen;
    submit("t2", 1'b0);
    check_eq("t2 strike",       32'(bus.strike),       32'd1);
    check_eq("t2 strike_count", 32'(bus.strike_count), 32'd1);
    check_eq("t2 state",        32'(bus.dbg_state),    ST_RUN);
    check_eq("t2 freq kept",    32'(bus.freq_idx),     32'd4);
    tick();
    check_eq("t2 strike low", 32'(bus.strike), 32'd0);
    check_eq("t2 strike width", 32'(strike_seen - strike_base), 32'd1);
    press(1'b1, 1'b0, 1);
    submit("t2b", 1'b0);
    check_eq("t2 solved", 32'(bus.solved), 32'd1);

    // saturation and simultaneous up/down
    start("t3");
    press(1'b1, 1'b0, 20);
    check_eq("t3 sat high", 32'(bus.freq_idx), 32'd15);
    press(1'b0, 1'b1, 20);
    check_eq("t3 sat low", 32'(bus.freq_idx), 32'd0);
    press(1'b1, 1'b0, 3);
    press(1'b1, 1'b1, 1);
    check_eq("t3 up+down", 32'(bus.freq_idx), 32'd3);

    // four wrong submissions saturate the strike count
    strike_base = strike_seen;
    for (int i = 0; i < 4; i++) submit("t4", 1'b0);
    tick();
    check_eq("t4 strike pulses", 32'(strike_seen - strike_base), 32'd4);
    check_eq("t4 strike_count",  32'(bus.strike_count), 32'd3);
    check_eq("t4 state",         32'(bus.dbg_state), ST_RUN);

    // reset while running at freq 7 with strikes recorded
    press(1'b1, 1'b0, 4);
    check_eq("t5 freq before reset", 32'(bus.freq_idx), 32'd7);
    reset = 1'b0;
    tick();
    check_all_zero("t5");
    reset = 1'b1;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    check_eq("t5 rearm blink_set",  32'(bus.blink_set),  32'd1);
    check_eq("t5 rearm blink_data", 32'(bus.blink_data), 32'd2);
    check_eq("t5 rearm state",      32'(bus.dbg_state),  ST_LOAD);

    // tx with simultaneous up judges the pre-edge index
    start("t6");
    press(1'b1, 1'b0, 5);
    submit("t6", 1'b1);
    check_eq("t6 solved", 32'(bus.solved),   32'd1);
    check_eq("t6 freq",   32'(bus.freq_idx), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
